// File: rtl/axil_wb_mport_bridge.sv
// Multi-port AXI-Lite to pipelined-Wishbone bridge.
// Round-robin arbitration between NPORTS AXI-Lite masters, one Wishbone
// transaction in flight, bus-error/timeout mapped to SLVERR, and writes
// with an all-zero strobe answered locally without touching the bus.
//
// Handshake rule: a transfer happens on a channel exactly in the cycle where
// its valid and ready are both high; valid never waits on ready, and payload
// (addr/data/strb or resp/rdata) is held stable while valid is high.
module axil_wb_mport_bridge #(
   parameter int NPORTS           = 2,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYCLES   = 255,
   localparam int DW        = C_AXI_DATA_WIDTH,
   localparam int AW        = C_AXI_ADDR_WIDTH,
   localparam int SW        = C_AXI_DATA_WIDTH / 8,
   localparam int AXILLSB   = $clog2(SW),
   localparam int WB_ADDR_W = C_AXI_ADDR_WIDTH - AXILLSB,
   localparam int GW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    i_axi_awvalid,
   output logic [NPORTS-1:0]    o_axi_awready,
   input  logic [NPORTS*AW-1:0] i_axi_awaddr,
   input  logic [NPORTS-1:0]    i_axi_wvalid,
   output logic [NPORTS-1:0]    o_axi_wready,
   input  logic [NPORTS*DW-1:0] i_axi_wdata,
   input  logic [NPORTS*SW-1:0] i_axi_wstrb,
   output logic [NPORTS-1:0]    o_axi_bvalid,
   input  logic [NPORTS-1:0]    i_axi_bready,
   output logic [NPORTS*2-1:0]  o_axi_bresp,
   input  logic [NPORTS-1:0]    i_axi_arvalid,
   output logic [NPORTS-1:0]    o_axi_arready,
   input  logic [NPORTS*AW-1:0] i_axi_araddr,
   output logic [NPORTS-1:0]    o_axi_rvalid,
   input  logic [NPORTS-1:0]    i_axi_rready,
   output logic [NPORTS*DW-1:0] o_axi_rdata,
   output logic [NPORTS*2-1:0]  o_axi_rresp,
   output logic                 o_wb_cyc,
   output logic                 o_wb_stb,
   output logic                 o_wb_we,
   output logic [WB_ADDR_W-1:0] o_wb_addr,
   output logic [DW-1:0]        o_wb_data,
   output logic [SW-1:0]        o_wb_sel,
   input  logic                 i_wb_stall,
   input  logic                 i_wb_ack,
   input  logic                 i_wb_err,
   input  logic [DW-1:0]        i_wb_data,
   output logic [GW-1:0]        o_grant,
   output logic [1:0]           fsm_state
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [NPORTS-1:0] wr_pend, rd_pend, any_pend, toggle;
   logic [GW-1:0]     rr_ptr, win;
   logic              found, win_wr, zero_strb;
   logic [AW-1:0]     aw_win, ar_win;
   logic [DW-1:0]     wd_win;
   logic [SW-1:0]     ws_win;
   logic              we_r;
   logic [1:0]        resp_r;
   logic [DW-1:0]     rdata_r;
   logic [TW-1:0]     to_cnt;
   logic              timeout_hit, ack_ok, err_ok, resp_hs;

   assign wr_pend   = i_axi_awvalid & i_axi_wvalid;
   assign rd_pend   = i_axi_arvalid;
   assign any_pend  = wr_pend | rd_pend;
   assign fsm_state = state;
   assign o_wb_we   = we_r & o_wb_cyc;

   // Round-robin scan from rr_ptr; per-port toggle splits read/write ties.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!found && any_pend[(int'(rr_ptr) + i) % NPORTS]) begin
            found = 1'b1;
            win   = GW'((int'(rr_ptr) + i) % NPORTS);
         end
      end
      win_wr    = wr_pend[win] && (!rd_pend[win] || !toggle[win]);
      aw_win    = i_axi_awaddr[int'(win)*AW +: AW];
      ar_win    = i_axi_araddr[int'(win)*AW +: AW];
      wd_win    = i_axi_wdata[int'(win)*DW +: DW];
      ws_win    = i_axi_wstrb[int'(win)*SW +: SW];
      zero_strb = win_wr && (ws_win == '0);
   end

   // Slave completion qualifiers: an ack beats err, and either beats timeout.
   always_comb begin
      ack_ok      = i_wb_ack && ((state == S_WAIT) || (state == S_REQ && !i_wb_stall));
      err_ok      = !ack_ok && i_wb_err &&
                    ((state == S_WAIT) || (state == S_REQ && !i_wb_stall));
      timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
      resp_hs     = we_r ? i_axi_bready[o_grant] : i_axi_rready[o_grant];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (found) state_nxt = zero_strb ? S_RESP : S_REQ;
         S_REQ: begin
            if (ack_ok || err_ok || timeout_hit) state_nxt = S_RESP;
            else if (!i_wb_stall)                state_nxt = S_WAIT;
         end
         S_WAIT: if (ack_ok || err_ok || timeout_hit) state_nxt = S_RESP;
         S_RESP: if (resp_hs) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: readies only for the winner, valids only for the owner.
   always_comb begin
      o_axi_awready = '0;
      o_axi_wready  = '0;
      o_axi_arready = '0;
      o_axi_bvalid  = '0;
      o_axi_rvalid  = '0;
      o_axi_bresp   = '0;
      o_axi_rresp   = '0;
      o_axi_rdata   = '0;
      o_wb_cyc      = 1'b0;
      o_wb_stb      = 1'b0;
      case (state)
         S_IDLE: begin
            if (found && win_wr) begin
               o_axi_awready[win] = 1'b1;
               o_axi_wready[win]  = 1'b1;
            end else if (found) begin
               o_axi_arready[win] = 1'b1;
            end
         end
         S_REQ: begin
            o_wb_cyc = 1'b1;
            o_wb_stb = 1'b1;
         end
         S_WAIT: o_wb_cyc = 1'b1;
         S_RESP: begin
            if (we_r) o_axi_bvalid[o_grant] = 1'b1;
            else      o_axi_rvalid[o_grant] = 1'b1;
         end
         default: ;
      endcase
      for (int p = 0; p < NPORTS; p++) begin
         if (GW'(p) == o_grant) begin
            o_axi_bresp[2*p +: 2]  = we_r ? resp_r : 2'b00;
            o_axi_rresp[2*p +: 2]  = we_r ? 2'b00 : resp_r;
            o_axi_rdata[p*DW +: DW] = we_r ? '0 : rdata_r;
         end
      end
   end

   // Grant capture, arbitration state, timeout counter and response latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         toggle    <= '0;
         o_grant   <= '0;
         we_r      <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
         o_wb_sel  <= '0;
         resp_r    <= 2'b00;
         rdata_r   <= '0;
         to_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  rr_ptr      <= (int'(win) == NPORTS - 1) ? '0 : win + 1'b1;
                  toggle[win] <= ~toggle[win];
                  o_grant     <= win;
                  we_r        <= win_wr;
                  resp_r      <= 2'b00;
                  rdata_r     <= '0;
                  to_cnt      <= '0;
                  if (win_wr) begin
                     o_wb_addr <= aw_win[AW-1:AXILLSB];
                     o_wb_data <= wd_win;
                     o_wb_sel  <= ws_win;
                  end else begin
                     o_wb_addr <= ar_win[AW-1:AXILLSB];
                     o_wb_data <= '0;
                     o_wb_sel  <= '1;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (ack_ok) begin
                  resp_r <= 2'b00;
                  if (!we_r) rdata_r <= i_wb_data;
               end else if (err_ok) begin
                  resp_r  <= 2'b10;
                  rdata_r <= '0;
               end else if (timeout_hit) begin
                  resp_r  <= 2'b10;
                  rdata_r <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_wb_mport_bridge.sv
// Directed bench for axil_wb_mport_bridge (2 ports, 32-bit data, 16-bit addr).
module tb_axil_wb_mport_bridge;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     awvalid = '0, wvalid = '0, bready = '0, arvalid = '0, rready = '0;
  logic [NP*AW-1:0]  awaddr = '0, araddr = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP*SW-1:0]  wstrb = '0;
  logic [NP-1:0]     awready, wready, bvalid, arready, rvalid;
  logic [NP*2-1:0]   bresp, rresp;
  logic [NP*DW-1:0]  rdata;
  logic              wb_cyc, wb_stb, wb_we;
  logic [13:0]       wb_addr;
  logic [DW-1:0]     wb_wdata;
  logic [SW-1:0]     wb_sel;
  logic              wb_stall = 1'b0, man_ack = 1'b0, man_err = 1'b0, auto_ack = 1'b0;
  logic              wb_ack, wb_err;
  logic [DW-1:0]     wb_rdata = '0;
  logic [0:0]        grant;
  logic [1:0]        fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  assign wb_ack = man_ack | (auto_ack & wb_stb & ~wb_stall);
  assign wb_err = man_err;

  axil_wb_mport_bridge #(
    .NPORTS(NP), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
    .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_araddr(araddr),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
    .o_grant(grant), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          stall;
    bit          err;
    logic [31:0] ack_data;
    logic [13:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];
  logic [DW-1:0] exp_q[$];

  // One transaction; entered and left 1 time unit after a rising edge.
  task automatic run_txn(input vec_t v);
    int p = v.port;
    int stb_cnt = 0;
    logic [1:0] onehot;
    onehot = 2'(1 << p);
    if (v.is_wr) begin
      awvalid[p] = 1'b1; wvalid[p] = 1'b1;
      awaddr[p*AW +: AW] = v.addr; wdata[p*DW +: DW] = v.wdata; wstrb[p*SW +: SW] = v.strb;
    end else begin
      arvalid[p] = 1'b1; araddr[p*AW +: AW] = v.addr;
    end
    @(negedge clk);
    if (v.is_wr) begin
      check("awready", awready, onehot);
      check("wready", wready, onehot);
    end else begin
      check("arready", arready, onehot);
    end
    @(posedge clk); #1;
    awvalid = '0; wvalid = '0; arvalid = '0;
    for (int k = 0; k <= v.stall; k++) begin
      wb_stall = (k < v.stall);
      if (k == v.stall) begin
        wb_rdata = v.ack_data;
        if (v.err) man_err = 1'b1; else man_ack = 1'b1;
      end
      @(negedge clk);
      if (wb_stb) stb_cnt++;
      if (k == 0) begin
        check("wb_cyc", wb_cyc, 1);
        check("wb_addr", wb_addr, v.exp_addr);
        check("wb_sel", wb_sel, v.exp_sel);
        check("wb_we", wb_we, v.is_wr);
        check("grant", grant, p);
        if (v.is_wr) check("wb_data", wb_wdata, v.wdata);
      end
      @(posedge clk); #1;
    end
    man_ack = 1'b0; man_err = 1'b0; wb_stall = 1'b0;
    check("stb_cycles", stb_cnt, v.stall + 1);
    @(negedge clk);
    check("cyc_dropped", wb_cyc, 0);
    if (v.is_wr) begin
      check("bvalid", bvalid, onehot);
      check("bresp", bresp[2*p +: 2], v.exp_resp);
      bready[p] = 1'b1;
    end else begin
      check("rvalid", rvalid, onehot);
      check("rresp", rresp[2*p +: 2], v.exp_resp);
      if (!v.err) check("rdata", rdata[p*DW +: DW], v.exp_rdata);
      rready[p] = 1'b1;
    end
    @(posedge clk); #1;
    bready = '0; rready = '0;
    @(negedge clk);
    check("valid_cleared", {bvalid, rvalid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int cyc_cnt, grants, cnt0, cnt1, model_ptr, got;
    vec_t rv;

    vecs[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,      14'h0004, 4'hF, 2'b00, 32'h0};
    vecs[1] = '{1, 1'b0, 16'h0020, 32'h0,        4'h0, 3, 1'b0, 32'h12345678, 14'h0008, 4'hF, 2'b00, 32'h12345678};
    vecs[2] = '{1, 1'b1, 16'h00FC, 32'hA5A5A5A5, 4'h3, 1, 1'b0, 32'h0,      14'h003F, 4'h3, 2'b00, 32'h0};
    vecs[3] = '{0, 1'b0, 16'hFFFC, 32'h0,        4'h0, 0, 1'b0, 32'hCAFEF00D, 14'h3FFF, 4'hF, 2'b00, 32'hCAFEF00D};
    vecs[4] = '{1, 1'b1, 16'h0100, 32'h0BADC0DE, 4'hC, 0, 1'b1, 32'h0,      14'h0040, 4'hC, 2'b10, 32'h0};
    vecs[5] = '{0, 1'b0, 16'h0044, 32'h0,        4'h0, 2, 1'b1, 32'h0,      14'h0011, 4'hF, 2'b10, 32'h0};
    vecs[6] = '{1, 1'b0, 16'h0008, 32'h0,        4'h0, 1, 1'b0, 32'h00C0FFEE, 14'h0002, 4'hF, 2'b00, 32'h00C0FFEE};

    // reset state
    #3;
    check("rst_ready", {awready, wready, arready}, 0);
    check("rst_valid", {bvalid, rvalid}, 0);
    check("rst_wb_ctl", {wb_cyc, wb_stb, wb_we}, 0);
    check("rst_wb_payload", {wb_addr, wb_wdata, wb_sel}, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant", grant, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // table-driven transactions
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // timeout: slave never answers a read on port 0
    arvalid[0] = 1'b1; araddr[15:0] = 16'h0080;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = '0;
    cyc_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!wb_cyc) break;
      cyc_cnt++;
      @(posedge clk); #1;
    end
    check("to_cyc_cycles", cyc_cnt, 255);
    check("to_rvalid", rvalid, 2'b01);
    check("to_rresp", rresp[1:0], 2'b10);
    check("to_rdata", rdata[31:0], 0);
    rready[0] = 1'b1;
    @(posedge clk); #1;
    rready = '0;

    // reset while waiting for an ack
    arvalid[1] = 1'b1; araddr[31:16] = 16'h0030;
    @(posedge clk); #1;
    arvalid = '0;
    @(posedge clk); #1;
    check("wait_cyc", {wb_cyc, wb_stb}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wb", {wb_cyc, wb_stb, wb_we}, 0);
    check("async_rst_valid", {bvalid, rvalid, awready, arready}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rv = '{1, 1'b0, 16'h0030, 32'h0, 4'h0, 0, 1'b0, 32'h600DF00D, 14'h000C, 4'hF, 2'b00, 32'h600DF00D};
    run_txn(rv);

    // round robin: both ports read back to back
    araddr = {16'h0004, 16'h0000};
    arvalid = 2'b11; rready = 2'b11; auto_ack = 1'b1;
    model_ptr = 0; grants = 0; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 60 && grants < 8; k++) begin
      @(negedge clk);
      if (arready != 0) begin
        exp_q.push_back(DW'(model_ptr));
        model_ptr = (model_ptr + 1) % NP;
        got = (arready == 2'b10) ? 1 : 0;
        check("rr_grant", got, exp_q.pop_front());
        if (got == 0) cnt0++; else cnt1++;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 8) arvalid = '0;
    end
    check("rr_total", grants, 8);
    check("rr_port0", cnt0, 4);
    check("rr_port1", cnt1, 4);
    repeat (3) begin @(posedge clk); #1; end
    auto_ack = 1'b0; rready = '0;

    // port 0: write and read together; zero-strobe write first, no bus cycle
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; awaddr[15:0] = 16'h0200; wstrb[3:0] = 4'h0;
    arvalid[0] = 1'b1; araddr[15:0] = 16'h0300;
    @(negedge clk);
    check("prio_awready", awready, 2'b01);
    check("prio_arready", arready, 2'b00);
    @(posedge clk); #1;
    awvalid = '0; wvalid = '0;
    @(negedge clk);
    check("zs_no_cyc", wb_cyc, 0);
    check("zs_bvalid", bvalid, 2'b01);
    check("zs_bresp", bresp[1:0], 2'b00);
    bready[0] = 1'b1;
    @(posedge clk); #1;
    bready = '0;
    @(negedge clk);
    check("prio_read_next", arready, 2'b01);
    @(posedge clk); #1;
    arvalid = '0; man_ack = 1'b1; wb_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("prio_rd_addr", wb_addr, 14'h00C0);
    check("prio_rd_we", wb_we, 0);
    @(posedge clk); #1;
    man_ack = 1'b0;
    @(negedge clk);
    check("prio_rvalid", rvalid, 2'b01);
    check("prio_rdata", rdata[31:0], 32'h55AA55AA);
    rready[0] = 1'b1;
    @(posedge clk); #1;
    rready = '0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard stop if the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axil_wb_mport_bridge.md
Name: axil_wb_mport_bridge

Overview:
- Multi-port AXI-Lite to pipelined-Wishbone bridge; lets NPORTS AXI-Lite masters (core I-port, D-port, DMA) share one Wishbone slave such as the SDRAM controller.
- Round-robin arbitration, one Wishbone transaction in flight, bus-error and timeout mapping to SLVERR, and zero-strobe write elision.

Parameters:
- NPORTS, 2: number of AXI-Lite slave ports (1..8).
- C_AXI_DATA_WIDTH, 32: AXI/WB data width (32 or 64).
- C_AXI_ADDR_WIDTH, 16: AXI byte-address width.
- TIMEOUT_CYCLES, 255: cycles from STB issue to forced SLVERR; 0 disables the timeout.
- Local AXILLSB = $clog2(C_AXI_DATA_WIDTH/8); WB_ADDR_W = C_AXI_ADDR_WIDTH-AXILLSB.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- i_axi_awvalid/o_axi_awready/i_axi_wvalid/o_axi_wready  in/out/in/out  NPORTS each  per-port AW/W handshakes.
- i_axi_awaddr  in  NPORTS*C_AXI_ADDR_WIDTH  write addresses; port p at slice p.
- i_axi_wdata  in  NPORTS*C_AXI_DATA_WIDTH  write data.
- i_axi_wstrb  in  NPORTS*C_AXI_DATA_WIDTH/8  byte strobes.
- o_axi_bvalid/i_axi_bready  out/in  NPORTS  write response handshake.
- o_axi_bresp  out  NPORTS*2  write responses.
- i_axi_arvalid/o_axi_arready  in/out  NPORTS  read address handshake.
- i_axi_araddr  in  NPORTS*C_AXI_ADDR_WIDTH  read addresses.
- o_axi_rvalid/i_axi_rready  out/in  NPORTS  read data handshake.
- o_axi_rdata  out  NPORTS*C_AXI_DATA_WIDTH  read data.
- o_axi_rresp  out  NPORTS*2  read responses.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone pipelined-mode controls.
- o_wb_addr  out  WB_ADDR_W  word address = axi_addr>>AXILLSB.
- o_wb_data  out  C_AXI_DATA_WIDTH  write data.
- o_wb_sel  out  C_AXI_DATA_WIDTH/8  byte select (= wstrb; all-ones on read).
- i_wb_stall, i_wb_ack, i_wb_err  in  1  slave status.
- i_wb_data  in  C_AXI_DATA_WIDTH  read data.
- o_grant  out  $clog2(NPORTS) (min 1)  index of port owning the bus (debug/perf).

Behaviour:
- Reset (async): all valid/ready/cyc/stb/we outputs 0; bresp/rresp/rdata/addr/data/sel 0; RR pointer 0; per-port rw-toggle 0; FSM IDLE.
- Port request: write pending = awvalid&wvalid (AW and W accepted together only); read pending = arvalid. If both pending, per-port toggle picks; toggle flips after each grant of that port; toggle=0 prefers write.
- Arbiter: in IDLE, scan ports starting at RR pointer, pick first pending; pointer <= winner+1 (wraps to 0 at NPORTS).
- FSM IDLE: on grant, same cycle assert awready&wready (or arready) of winner only, capture addr/data/strb/we, register o_grant. Write with wstrb==0 -> RESP with OKAY, no WB access. Else -> REQ. Other ports' readies stay 0.
- REQ: cyc=1, stb=1, payload stable. When !i_wb_stall, stb drops next cycle; if ack/err in that same cycle -> RESP directly, else -> WAIT.
- WAIT: cyc=1, stb=0 until ack (OKAY, capture i_wb_data on read) or err (SLVERR=2'b10) -> RESP; cyc drops on transition.
- Timeout: counter loads at REQ entry, counts in REQ and WAIT; on reaching TIMEOUT_CYCLES, cyc/stb drop, SLVERR, rdata=0, -> RESP. ack and timeout in the same cycle: ack wins.
- RESP: bvalid or rvalid asserted on winning port only, resp/rdata held stable until bready/rready. Handshake cycle -> IDLE. Next grant at earliest one cycle later.
- Latency: valid to stb = 1 cycle; zero-wait slave (ack with stb) gives valid to rvalid = 2 cycles.
- Only one transaction outstanding; stray ack/err in IDLE/RESP is ignored.
- NPORTS=1: arbiter degenerates; o_grant is constant 0.
- Reset mid-transaction: drops cyc immediately; pending response lost; masters must also be reset.

Test Plan:
- Single write, port0 addr 0x0010, data 0xDEADBEEF, strb 0xF, zero-wait slave -> wb_addr 0x0004, sel 0xF, we=1; bvalid[0] with bresp 0 two cycles after valid.
- Read, port1 addr 0x0020, slave stalls 3 cycles then acks 0x12345678 -> stb held 4 cycles; rdata slice1 = 0x12345678, rresp 0.
- Both ports issue reads every cycle, 8 transactions -> grants alternate 0,1,0,1…; each port gets exactly 4.
- Port0 has write and read pending simultaneously -> write granted first, then read; wstrb=0 write -> bresp OKAY with no cyc pulse.
- Slave never acks, TIMEOUT_CYCLES=255 -> cyc drops after 255 cycles, rresp 2'b10, rdata 0; slave i_wb_err -> bresp 2'b10.
- rst asserted during WAIT -> cyc/stb/all valids 0 asynchronously; after release, a new read completes normally.
